// File: rtl/cnn_stream_sequencer_if.sv
// ---------------------------------------------------------------------------
// cnn_stream_sequencer_if
// Bundles the host word stream, the pipeline handshake and the sequencer
// status outputs.
//   master : host/pipeline side (drives in_data, in_valid, pipe_stall, frame_done)
//   slave  : sequencer side (drives upstream_stall, pipe_*, cur_tag,
//            frames_in_flight, err_format)
// ---------------------------------------------------------------------------
interface cnn_stream_sequencer_if #(
    parameter int MAX_FRAMES_IN_FLIGHT = 2
);
    logic [31:0] in_data;
    logic        in_valid;
    logic        upstream_stall;
    logic [31:0] pipe_data;
    logic        pipe_valid;
    logic        pipe_stall;
    logic        pipe_flush;
    logic        frame_done;
    logic [5:0]  cur_tag;
    logic [$clog2(MAX_FRAMES_IN_FLIGHT+1)-1:0] frames_in_flight;
    logic        err_format;

    modport master (
        output in_data, in_valid, pipe_stall, frame_done,
        input  upstream_stall, pipe_data, pipe_valid, pipe_flush,
               cur_tag, frames_in_flight, err_format
    );

    modport slave (
        input  in_data, in_valid, pipe_stall, frame_done,
        output upstream_stall, pipe_data, pipe_valid, pipe_flush,
               cur_tag, frames_in_flight, err_format
    );
endinterface

// File: rtl/cnn_stream_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_stream_sequencer
// Front-end controller between the host word stream and the CNN pipeline.
// Decodes the control bits of each word, runs flush commands, tracks the
// row/column position within a frame, limits resident frames with a credit
// count and flags malformed streams.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : cnn_stream_sequencer_if.slave
//            in_data/in_valid/upstream_stall     host word stream
//            pipe_data/pipe_valid/pipe_stall     single-register output stage
//            pipe_flush                          pipeline clear pulse
//            frame_done                          frame retired by the pipeline
//            cur_tag/frames_in_flight/err_format status
//
// Build option: define SEQ_FORMAT_CHECK_EN to build the frame-last and tag
// checks; otherwise err_format is tied low.
// ---------------------------------------------------------------------------
module cnn_stream_sequencer #(
    parameter int IMG_WIDTH            = 28,
    parameter int IMG_HEIGHT           = 28,
    parameter int VALUES_PER_WORD      = 1,
    parameter int MAX_FRAMES_IN_FLIGHT = 2,
    parameter int FLUSH_CYCLES         = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    cnn_stream_sequencer_if.slave bus
);
    localparam int WPR = (IMG_WIDTH + VALUES_PER_WORD - 1) / VALUES_PER_WORD;
    localparam int CW  = $clog2(WPR + 1);
    localparam int RW  = $clog2(IMG_HEIGHT + 1);
    localparam int FW  = $clog2(MAX_FRAMES_IN_FLIGHT + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]    r_state;
    logic [FCW-1:0] r_flush_cnt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [FW-1:0] r_fif;
    logic [5:0]    r_cur_tag;
    logic [31:0]   r_pipe_data;
    logic          r_pipe_valid;
    logic          r_err;

    logic w_flushing, w_at_start, w_full, w_stall, w_accept;
    logic w_flush_cmd, w_data_acc, w_col_last, w_row_last, w_inc, w_dec;

    assign w_flushing  = (r_state == ST_FLUSH);
    assign w_at_start  = (r_row == '0) && (r_col == '0);
    assign w_full      = (r_fif == FW'(MAX_FRAMES_IN_FLIGHT));
    // Flush words bypass the credit stall so a stuck stream can always be cleared.
    assign w_stall     = w_flushing
                       || (r_pipe_valid && bus.pipe_stall)
                       || (w_at_start && w_full && !bus.in_data[31]);
    assign w_accept    = bus.in_valid && !w_stall;
    assign w_flush_cmd = w_accept &&  bus.in_data[31];
    assign w_data_acc  = w_accept && !bus.in_data[31];
    assign w_col_last  = (r_col == CW'(WPR - 1));
    assign w_row_last  = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_inc       = w_data_acc && w_at_start;
    // A retire at zero credits or during flush has nothing to retire.
    assign w_dec       = bus.frame_done && (r_fif != '0) && !w_flushing;

    // State and flush length counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else if (w_flush_cmd) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
        end else if (w_flushing) begin
            if (r_flush_cnt == '0) r_state     <= ST_RUN;
            else                   r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Output register; a flush discards any word still held here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pipe_data  <= '0;
            r_pipe_valid <= 1'b0;
        end else if (w_flushing || w_flush_cmd) begin
            r_pipe_valid <= 1'b0;
        end else if (w_data_acc) begin
            r_pipe_data  <= {1'b0, bus.in_data[30:0]};
            r_pipe_valid <= 1'b1;
        end else if (!bus.pipe_stall) begin
            r_pipe_valid <= 1'b0;
        end
    end

    // Position and credit tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
            r_fif <= '0;
        end else if (w_flushing || w_flush_cmd) begin
            r_row <= '0;
            r_col <= '0;
            r_fif <= '0;
        end else begin
            if (w_data_acc) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            case ({w_inc, w_dec})
                2'b10:   r_fif <= r_fif + 1'b1;
                2'b01:   r_fif <= r_fif - 1'b1;
                default: r_fif <= r_fif;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     r_cur_tag <= '0;
        else if (w_inc) r_cur_tag <= bus.in_data[29:24];
    end

`ifdef SEQ_FORMAT_CHECK_EN
    logic w_bad_last, w_bad_tag;
    assign w_bad_last = bus.in_data[30] != (w_row_last && w_col_last);
    // The start word defines the frame tag, so only later words are compared.
    assign w_bad_tag  = !w_at_start && (bus.in_data[29:24] != r_cur_tag);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                                         r_err <= 1'b0;
        else if (w_flushing || w_flush_cmd)                 r_err <= 1'b0;
        else if (w_data_acc && (w_bad_last || w_bad_tag))   r_err <= 1'b1;
    end
`else
    assign r_err = 1'b0;
`endif

    assign bus.upstream_stall   = w_stall;
    assign bus.pipe_data        = r_pipe_data;
    assign bus.pipe_valid       = r_pipe_valid;
    assign bus.pipe_flush       = w_flushing;
    assign bus.cur_tag          = r_cur_tag;
    assign bus.frames_in_flight = r_fif;
    assign bus.err_format       = r_err;
endmodule

// File: tb/tb_cnn_stream_sequencer.sv
// Scoreboard bench: the driver pushes the expected pipeline word for each
// forwarded host word; a monitor pops and compares on every pipeline transfer.
module tb_cnn_stream_sequencer;
    localparam int FRAME = 28 * 28;
`ifdef SEQ_FORMAT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    cnn_stream_sequencer_if #(.MAX_FRAMES_IN_FLIGHT(2)) bus ();

    cnn_stream_sequencer #(
        .IMG_WIDTH(28), .IMG_HEIGHT(28), .VALUES_PER_WORD(1),
        .MAX_FRAMES_IN_FLIGHT(2), .FLUSH_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [5:0] tag, input int k, input logic lf);
        return {1'b0, lf, tag, 8'hA5, 16'(k)};
    endfunction

    // Monitor: every transfer into the pipeline must match the queue head.
    always @(negedge clock) begin
        if (reset && bus.pipe_valid && !bus.pipe_stall) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word actual=%0h expected=none", bus.pipe_data);
            end else begin
                chk("pipe_data", bus.pipe_data, sb.pop_front());
            end
        end
    end

    // Present a word until accepted (bounded), then drop in_valid.
    task automatic send(input logic [31:0] w, input bit push);
        int t;
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        t = 0;
        @(negedge clock);
        while (bus.upstream_stall && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (t >= 2000) begin
            total++;
            bad++;
            $display("FAIL accept_timeout actual=stalled expected=accepted word=%0h", w);
        end else if (push) begin
            sb.push_back({1'b0, w[30:0]});
        end
        @(posedge clock);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic send_range(input logic [5:0] tag, input int first, input int last, input int flag_at);
        for (int k = first; k <= last; k++) send(word(tag, k, k == flag_at), 1'b1);
    endtask

    task automatic do_flush(input string nm);
        int nf, ns, nv;
        nf = 0; ns = 0; nv = 0;
        send(32'h8000_0000, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            nf += int'(bus.pipe_flush);
            ns += int'(bus.upstream_stall);
            nv += int'(bus.pipe_valid);
        end
        chk({nm, "_flush_cycles"}, 32'(nf), 32'd4);
        chk({nm, "_stall_cycles"}, 32'(ns), 32'd4);
        chk({nm, "_valid_cycles"}, 32'(nv), 32'd0);
        chk({nm, "_fif"}, 32'(bus.frames_in_flight), 32'd0);
        chk({nm, "_err"}, 32'(bus.err_format), 32'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ns, nd, nv;
        bus.in_data = '0; bus.in_valid = 1'b0;
        bus.pipe_stall = 1'b0; bus.frame_done = 1'b0;
        #12;
        chk("rst_pipe_valid", 32'(bus.pipe_valid), 0);
        chk("rst_pipe_data",  bus.pipe_data, 0);
        chk("rst_flush",      32'(bus.pipe_flush), 0);
        chk("rst_stall",      32'(bus.upstream_stall), 0);
        chk("rst_tag",        32'(bus.cur_tag), 0);
        chk("rst_fif",        32'(bus.frames_in_flight), 0);
        chk("rst_err",        32'(bus.err_format), 0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;

        // Flush right after reset
        do_flush("flush0");

        // One full frame, tag 0
        send_range(6'd0, 1, FRAME, FRAME);
        chk("f1_fif", 32'(bus.frames_in_flight), 1);
        chk("f1_err", 32'(bus.err_format), 0);
        chk("f1_tag", 32'(bus.cur_tag), 0);

        // Credit limit: frames 0 and 1 resident, third frame start stalls
        do_flush("flush1");
        send_range(6'd0, 1, FRAME, FRAME);
        send_range(6'd1, 1, FRAME, FRAME);
        chk("cr_fif_full", 32'(bus.frames_in_flight), 2);
        bus.in_data = word(6'd2, 1, 1'b0);
        bus.in_valid = 1'b1;
        ns = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            ns += int'(bus.upstream_stall);
        end
        chk("cr_stall_cycles", 32'(ns), 5);
        @(posedge clock); #1 bus.frame_done = 1'b1;
        @(negedge clock);
        chk("cr_stall_on_done", 32'(bus.upstream_stall), 1);
        @(posedge clock); #1 bus.frame_done = 1'b0;
        @(negedge clock);
        chk("cr_stall_after_done", 32'(bus.upstream_stall), 0);
        sb.push_back({1'b0, word(6'd2, 1, 1'b0)});
        @(posedge clock); #1 bus.in_valid = 1'b0;
        chk("cr_fif_after", 32'(bus.frames_in_flight), 2);
        chk("cr_tag", 32'(bus.cur_tag), 2);
        send_range(6'd2, 2, FRAME, FRAME);

        // Back-pressure held for 10 cycles mid-row
        do_flush("flush2");
        send_range(6'd5, 1, 10, 0);
        bus.pipe_stall = 1'b1;
        bus.in_data = word(6'd5, 11, 1'b0);
        bus.in_valid = 1'b1;
        ns = 0; nd = 0; nv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            ns += int'(bus.upstream_stall);
            nv += int'(bus.pipe_valid);
            nd += int'(bus.pipe_data == {1'b0, word(6'd5, 10, 1'b0)});
        end
        chk("bp_stall_cycles", 32'(ns), 10);
        chk("bp_valid_cycles", 32'(nv), 10);
        chk("bp_data_stable",  32'(nd), 10);
        @(posedge clock); #1 bus.pipe_stall = 1'b0;
        // Row 0 ends at word 28: a frame-last flag there is malformed
        send_range(6'd5, 11, 28, 28);
        chk("fmt_last_err", 32'(bus.err_format), 32'(EXP_ERR));
        send_range(6'd5, 29, 31, 0);
        chk("fmt_last_sticky", 32'(bus.err_format), 32'(EXP_ERR));
        do_flush("flush3");

        // Tag change mid-frame
        send_range(6'd3, 1, 3, 0);
        chk("fmt_tag_ok", 32'(bus.err_format), 0);
        send(word(6'd4, 4, 1'b0), 1'b1);
        chk("fmt_tag_err", 32'(bus.err_format), 32'(EXP_ERR));
        send_range(6'd3, 5, 6, 0);
        chk("fmt_tag_sticky", 32'(bus.err_format), 32'(EXP_ERR));
        do_flush("flush4");

        // frame_done coincident with a frame start at count 1
        send_range(6'd7, 1, FRAME, FRAME);
        chk("fd_fif1", 32'(bus.frames_in_flight), 1);
        bus.frame_done = 1'b1;
        send(word(6'd8, 1, 1'b0), 1'b1);
        bus.frame_done = 1'b0;
        chk("fd_coincident", 32'(bus.frames_in_flight), 1);
        chk("fd_tag", 32'(bus.cur_tag), 8);
        bus.frame_done = 1'b1;
        @(posedge clock); #1 bus.frame_done = 1'b0;
        chk("fd_dec", 32'(bus.frames_in_flight), 0);
        bus.frame_done = 1'b1;
        @(posedge clock); #1 bus.frame_done = 1'b0;
        chk("fd_at_zero", 32'(bus.frames_in_flight), 0);
        do_flush("flush5");

        repeat (3) @(posedge clock);
        #1 chk("sb_drained", 32'(sb.size()), 0);

        // Asynchronous reset mid-frame
        send_range(6'd9, 1, 5, 0);
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.pipe_valid), 0);
        chk("arst_data",  bus.pipe_data, 0);
        chk("arst_fif",   32'(bus.frames_in_flight), 0);
        chk("arst_tag",   32'(bus.cur_tag), 0);
        sb.delete();
        @(posedge clock); #1 reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cnn_stream_sequencer.md
# cnn_stream_sequencer

Front-end controller between the processor word stream and the CNN pipeline. It decodes the control byte of each 32-bit input word, executes flush commands, tracks row and column position within a frame, and limits the number of frames resident in the pipeline using a frame credit count. It also flags malformed streams. The block is instantiated inside `de1soc_top`, directly behind the host-facing `in_data`/`in_valid`/`upstream_stall` ports.

## Interface
- `IMG_WIDTH`, 28: pixels per row.
- `IMG_HEIGHT`, 28: rows per frame.
- `VALUES_PER_WORD`, 1: pixels per input word (1..3).
- `MAX_FRAMES_IN_FLIGHT`, 2: frame credit limit (≥1).
- `FLUSH_CYCLES`, 4: length of the `pipe_flush` pulse (≥1).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `in_data` in 32: host word.
  - [31] flush command.
  - [30] frame-last flag.
  - [29:24] tag.
  - [23:0] pixels.
- `in_valid` in 1: host word valid.
- `upstream_stall` out 1: host must hold the word.
- `pipe_data` out 32: word to the pipeline.
- `pipe_valid` out 1: `pipe_data` valid.
- `pipe_stall` in 1: pipeline back-pressure.
- `pipe_flush` out 1: pipeline clear.
- `frame_done` in 1: one-cycle pulse when the pipeline emits a frame's final output word.
- `cur_tag` out 6: tag of the current frame.
- `frames_in_flight` out $clog2(MAX_FRAMES_IN_FLIGHT+1): outstanding frames.
- `err_format` out 1: sticky stream-format error.

## Operation
- WPR = ceil(IMG_WIDTH/VALUES_PER_WORD) words per row. `col` counts 0..WPR-1 and `row` counts 0..IMG_HEIGHT-1. `at_start` = (row==0 && col==0).
- A word is accepted when `in_valid && !upstream_stall`.
- The output stage is a single register. It can load when `!pipe_valid || !pipe_stall`.
- States: RUN, FLUSH.
- **RUN:**
  - Stall condition: `upstream_stall` = (`pipe_valid && pipe_stall`) || (`at_start && frames_in_flight==MAX_FRAMES_IN_FLIGHT && !in_data[31]`).
  - Accepted word with [31]=1: the word is not forwarded. Go to FLUSH.
  - Accepted data word: `pipe_data` <= {1'b0, `in_data`[30:0]} and `pipe_valid` <= 1. Advance `col`; on wrap, advance `row`; on frame end, wrap to 0/0.
  - If `at_start`: latch `cur_tag` <= [29:24] and increment `frames_in_flight`.
  - `pipe_valid` clears when the word is taken (`!pipe_stall`) and no new word is accepted.
- **FLUSH:**
  - `pipe_flush`=1 and `upstream_stall`=1 for exactly FLUSH_CYCLES cycles.
  - `pipe_valid` is forced to 0.
  - `row`, `col`, `frames_in_flight` and `err_format` clear to 0.
  - Then return to RUN.
- **`frames_in_flight` update:** +1 on frame start and −1 on `frame_done`. When both occur in the same cycle, the count is unchanged. A `frame_done` at zero is ignored. `frame_done` is ignored during FLUSH.
- **Format checks:** a data word's [30] must equal 1 exactly on the frame's last word (row==IMG_HEIGHT-1, col==WPR-1). The tag of every non-start word must equal `cur_tag`. A violation sets `err_format`, which stays set until flush or reset. Violating words are still forwarded unchanged.

## Timing
- Reset values:
  - State RUN.
  - `pipe_valid`=0, `pipe_data`=0, `pipe_flush`=0, `upstream_stall`=0.
  - `cur_tag`=0, `frames_in_flight`=0, `err_format`=0.
  - `row`=`col`=0.
- Latency: 1 cycle from acceptance to `pipe_valid`.
- Throughput: 1 word per cycle while `pipe_stall`=0.
- `upstream_stall` is combinational from `pipe_valid`, `pipe_stall`, state, counters and `in_data[31]`.
- `pipe_data` is held stable while `pipe_valid && pipe_stall`.
- Flush commands are accepted even when credits are exhausted.
- A flush word that is accepted while a word is still held in the output register discards that word.
- FLUSH occupies the cycles [N+1, N+FLUSH_CYCLES] after acceptance at cycle N. The first new word can be accepted at cycle N+FLUSH_CYCLES+1.
- Reset asserted mid-frame or mid-flush returns all outputs to their reset values immediately (asynchronous reset).

## Configuration
- `SEQ_FORMAT_CHECK_EN` defined: the frame-last and tag checks are built in, and `err_format` behaves as specified.
- `SEQ_FORMAT_CHECK_EN` undefined: the check logic is omitted and `err_format` is tied to 0. `cur_tag` is still latched.

## Test plan
- Reset, then a flush word 0x80000000: `pipe_flush` high for 4 cycles, `upstream_stall` high for those 4 cycles, `pipe_valid` never asserted.
- One 28×28 frame, tag 0, [30] set on word 784 only: 784 words forwarded in order with bit 31 cleared, `frames_in_flight`=1, `err_format`=0.
- Three back-to-back frames with tags 0,1,2 and no `frame_done`: the third frame's first word stalls until a `frame_done` pulse arrives, then is accepted one cycle later. `cur_tag`=2.
- `pipe_stall` held for 10 cycles mid-row: `pipe_data` stays stable, exactly one word is held, `upstream_stall` is high, and no word is lost or duplicated.
- [30] set on word 28 (row 0 end), or tag changed mid-frame: `err_format`=1 and sticky. A subsequent flush clears it to 0.
- `frame_done` coincident with a frame start at count 1: count stays 1. A `frame_done` at count 0 keeps the count at 0.
